// File: rtl/octa16_rf_pkg.sv
// Shared widths and the implemented-register range check for the register-file access path.
package octa16_rf_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 6;
  localparam int NUM_REGS   = 4;

  // Callers zero-extend the address to 32 bits so any ADDR_WIDTH can share one helper.
  function automatic logic in_rng(input logic [31:0] addr, input int unsigned num_regs);
    return addr < num_regs;
  endfunction

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Decode request, execute operand, writeback and reg-file port signals of the access controller.
interface reg_access_ctrl_if #(
  parameter int DATA_WIDTH = octa16_rf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = octa16_rf_pkg::ADDR_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_rs1;
  logic [ADDR_WIDTH-1:0] req_rs2;
  logic                  req_rs1_use;
  logic                  req_rs2_use;
  logic [ADDR_WIDTH-1:0] req_rd;
  logic                  req_rd_use;

  logic                  op_valid;
  logic                  op_ready;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;

  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;

  logic                  rf_rs1_en;
  logic                  rf_rs2_en;
  logic [ADDR_WIDTH-1:0] rf_rd_addr1;
  logic [ADDR_WIDTH-1:0] rf_rd_addr2;
  logic [DATA_WIDTH-1:0] rf_rd_data1;
  logic [DATA_WIDTH-1:0] rf_rd_data2;
  logic                  rf_wr_en;
  logic [ADDR_WIDTH-1:0] rf_wr_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;

  // slave: the access controller itself; master: decode/execute/writeback/reg-file side.
  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rs1_use, req_rs2_use, req_rd, req_rd_use,
    output req_ready,
    output op_valid, op_a, op_b,
    input  op_ready,
    input  wb_valid, wb_addr, wb_data,
    output rf_rs1_en, rf_rs2_en, rf_rd_addr1, rf_rd_addr2,
    input  rf_rd_data1, rf_rd_data2,
    output rf_wr_en, rf_wr_addr, rf_wr_data
  );

  modport master (
    output req_valid, req_rs1, req_rs2, req_rs1_use, req_rs2_use, req_rd, req_rd_use,
    input  req_ready,
    input  op_valid, op_a, op_b,
    output op_ready,
    output wb_valid, wb_addr, wb_data,
    input  rf_rs1_en, rf_rs2_en, rf_rd_addr1, rf_rd_addr2,
    output rf_rd_data1, rf_rd_data2,
    input  rf_wr_en, rf_wr_addr, rf_wr_data
  );

endinterface

// File: rtl/reg_access_ctrl_rf_scoreboard.sv
// Busy-bit scoreboard: one bit per implemented register, set at issue, cleared at writeback.
module rf_scoreboard
  import octa16_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = octa16_rf_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = octa16_rf_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic                  rs1_use,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic                  rs2_use,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  rd_use,
  output logic                  haz1,
  output logic                  haz2,
  output logic                  hazd
);

  logic [NUM_REGS-1:0] busy;

  function automatic logic busy_at(input logic [ADDR_WIDTH-1:0] a, input logic [NUM_REGS-1:0] v);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (a == ADDR_WIDTH'(i)) hit = v[i];
    end
    return hit;
  endfunction

  // A writeback landing this cycle resolves the hazard, since its data is forwarded.
  function automatic logic hazard(input logic use_it, input logic [ADDR_WIDTH-1:0] a,
                                  input logic [NUM_REGS-1:0] v, input logic wb_hit);
    return use_it && in_rng(32'(a), NUM_REGS) && busy_at(a, v) && !wb_hit;
  endfunction

  always_comb begin
    haz1 = hazard(rs1_use, rs1, busy, clr_en && (clr_addr == rs1));
    haz2 = hazard(rs2_use, rs2, busy, clr_en && (clr_addr == rs2));
    hazd = hazard(rd_use,  rd,  busy, clr_en && (clr_addr == rd));
  end

  // Set is checked first so a same-cycle issue to a register being written back stays busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (set_en && set_addr == ADDR_WIDTH'(i)) begin
          busy[i] <= 1'b1;
        end else if (clr_en && clr_addr == ADDR_WIDTH'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/reg_access_ctrl.sv
// Register-file access controller: operand read/forward, hazard stall and registered operand handoff.
module reg_access_ctrl
  import octa16_rf_pkg::*;
#(
  parameter int DATA_WIDTH = octa16_rf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = octa16_rf_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = octa16_rf_pkg::NUM_REGS
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_access_ctrl_if.slave   bus
);

  logic                  rng1, rng2, rng_wb;
  logic                  fwd1, fwd2;
  logic                  haz1, haz2, hazd;
  logic                  ready_int;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_a, sel_b;
  logic                  op_valid_q;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q;

  assign rng1   = in_rng(32'(bus.req_rs1), NUM_REGS);
  assign rng2   = in_rng(32'(bus.req_rs2), NUM_REGS);
  assign rng_wb = in_rng(32'(bus.wb_addr), NUM_REGS);

  assign fwd1 = bus.wb_valid && (bus.wb_addr == bus.req_rs1);
  assign fwd2 = bus.wb_valid && (bus.wb_addr == bus.req_rs2);

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    if (bus.req_rs1_use && rng1) sel_a = fwd1 ? bus.wb_data : bus.rf_rd_data1;
    if (bus.req_rs2_use && rng2) sel_b = fwd2 ? bus.wb_data : bus.rf_rd_data2;
  end

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (accept && bus.req_rd_use),
    .set_addr (bus.req_rd),
    .clr_en   (bus.wb_valid && rng_wb),
    .clr_addr (bus.wb_addr),
    .rs1      (bus.req_rs1),
    .rs1_use  (bus.req_rs1_use),
    .rs2      (bus.req_rs2),
    .rs2_use  (bus.req_rs2_use),
    .rd       (bus.req_rd),
    .rd_use   (bus.req_rd_use),
    .haz1     (haz1),
    .haz2     (haz2),
    .hazd     (hazd)
  );

  // Held low during reset so decode never sees a handshake the flops are not able to take.
  assign ready_int     = rst_n && (!op_valid_q || bus.op_ready) && !haz1 && !haz2 && !hazd;
  assign accept        = bus.req_valid && ready_int;
  assign bus.req_ready = ready_int;

  assign bus.rf_rs1_en   = bus.req_valid && bus.req_rs1_use && rng1;
  assign bus.rf_rs2_en   = bus.req_valid && bus.req_rs2_use && rng2;
  assign bus.rf_rd_addr1 = bus.req_rs1;
  assign bus.rf_rd_addr2 = bus.req_rs2;

  assign bus.rf_wr_en   = bus.wb_valid && rng_wb;
  assign bus.rf_wr_addr = bus.wb_addr;
  assign bus.rf_wr_data = bus.wb_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else if (accept) begin
      op_valid_q <= 1'b1;
      op_a_q     <= sel_a;
      op_b_q     <= sel_b;
    end else if (bus.op_ready) begin
      op_valid_q <= 1'b0;
    end
  end

  assign bus.op_valid = op_valid_q;
  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;

endmodule
